imm_ext_stage: RTL and testbench
================================

// Module: imm_ext_stage
// PURPOSE
//  Decode-stage immediate generator and buffer for the MIPS pipeline. Classifies each instruction by opcode/funct.
//  Produces the 32-bit extended operand (sign, zero, LUI, branch offset, shamt, jump target).
//  Holds results in a 2-entry skid buffer with valid/ready handshakes so ID/EX stalls never drop an operand.
//  Sits between the IF/ID register and the ID/EX register; EX consumes out_imm/out_mode.
// PARAMETERS
//  IMM_W     16  width of the instruction immediate field
//  OUT_W     32  width of the extended operand
//  BR_SHIFT  2   left shift applied to branch offsets
//  CNT_W     16  width of the issued-operand statistics counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      discard all buffered entries (branch mispredict / exception)
//  in_valid   in   1      instr is valid this cycle
//  in_ready   out  1      block can accept instr this cycle
//  instr      in   32     instruction word from IF/ID
//  out_valid  out  1      buffer head is valid
//  out_ready  in   1      ID/EX consumes head this cycle
//  out_imm    out  OUT_W  extended operand of buffer head
//  out_mode   out  3      mode of head: 0 SIGN, 1 ZERO, 2 LUI, 3 BRANCH, 4 SHAMT, 5 JUMP, 7 NONE
//  ext_count  out  CNT_W  number of operands popped since reset (wraps)
// BEHAVIOUR
//  Extension is combinational on instr and is captured into the buffer on accept.
//  - SIGN (op 0010xx addi/addiu/slti/sltiu, op[5]=1 loads/stores): {{16{imm[15]}},imm}
//  - ZERO (op 001100/001101/001110 andi/ori/xori): {16'b0,imm}
//  - LUI (op 001111): {imm,16'b0}
//  - BRANCH (op 000100/000101/000110/000111): sign-extended imm << BR_SHIFT, bits shifted out are dropped
//  - SHAMT (op 000000): {27'b0,instr[10:6]}
//  - JUMP (op 000010/000011): {6'b0,instr[25:0]}
//  - Any other opcode: mode NONE, out_imm 0
//  Buffer FSM states: EMPTY, HALF, FULL.
//  - in_ready = (state != FULL), driven from registered state only (no path from out_ready).
//  - out_valid = (state != EMPTY). out_imm/out_mode always reflect the oldest entry.
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
//  - EMPTY: push -> HALF.
//  - HALF: push only -> FULL; pop only -> EMPTY; push+pop -> HALF with the new entry as head.
//  - FULL: pop -> HALF, second entry becomes head; no push possible.
//  - Latency: instr accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY or popping.
//  - Ordering is strictly FIFO. Throughput is 1 per cycle in HALF with continuous push and pop.
//  - Out-of-range / idle: when out_valid=0, out_imm=0 and out_mode=NONE.
//  flush:
//  - Next state is EMPTY regardless of in_valid or out_ready; a same-cycle push is discarded.
//  - A pop in the flush cycle still counts (head was consumed).
//  ext_count increments by 1 on every pop and wraps to 0 at 2^CNT_W.
//  Reset (async, any time, including mid-operation):
//  - state EMPTY; out_valid 0; out_imm 0; out_mode 7; ext_count 0; in_ready 1 once reset deasserts.
//  - Buffered entries are discarded.
// TESTING
//  1 assert reset mid-stream with 2 entries held -> out_valid=0, out_imm=0, out_mode=7, ext_count=0, in_ready=1
//  2 push addi 0x2008FFFF then andi 0x3108FFFF, out_ready=1 -> out_imm 0xFFFFFFFF/SIGN, then 0x0000FFFF/ZERO, 1 cycle each
//  3 push lui 0x3C081234, beq 0x1000FFFE, sll 0x00084080 -> 0x12340000/LUI, 0xFFFFFFF8/BRANCH, 0x00000002/SHAMT
//  4 out_ready=0, present 3 instrs -> in_ready=0 after 2 accepts; raise out_ready -> all 3 emerge in order, none lost
//  5 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, state EMPTY, ext_count unchanged
//  6 8 back-to-back instrs with out_ready=1 -> 8 pops in 8 consecutive cycles, ext_count=8

Source files
------------

// File: rtl/imm_ext_stage.sv
// Decode-stage immediate generator for the MIPS pipeline, followed by a
// 2-entry skid buffer so ID/EX back-pressure never drops an extended operand.
module imm_ext_stage #(
  parameter int IMM_W    = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [2:0]       out_mode,
  output logic [CNT_W-1:0] ext_count
);

  typedef enum logic [2:0] {
    M_SIGN   = 3'd0,
    M_ZERO   = 3'd1,
    M_LUI    = 3'd2,
    M_BRANCH = 3'd3,
    M_SHAMT  = 3'd4,
    M_JUMP   = 3'd5,
    M_NONE   = 3'd7
  } mode_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  logic [5:0]       op;
  logic [IMM_W-1:0] imm;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] dec_imm;
  mode_t            dec_mode;

  always_comb begin
    op       = instr[31:26];
    imm      = instr[IMM_W-1:0];
    sext     = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    dec_imm  = '0;
    dec_mode = M_NONE;
    casez (op)
      6'b1?????, 6'b0010??: begin
        dec_mode = M_SIGN;
        dec_imm  = sext;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_mode = M_ZERO;
        dec_imm  = OUT_W'(imm);
      end
      6'b001111: begin
        dec_mode = M_LUI;
        dec_imm  = OUT_W'(imm) << IMM_W;
      end
      6'b0001??: begin
        dec_mode = M_BRANCH;
        dec_imm  = sext << BR_SHIFT;
      end
      6'b000000: begin
        dec_mode = M_SHAMT;
        dec_imm  = OUT_W'(instr[10:6]);
      end
      6'b00001?: begin
        dec_mode = M_JUMP;
        dec_imm  = OUT_W'(instr[25:0]);
      end
      default: begin
        dec_mode = M_NONE;
        dec_imm  = '0;
      end
    endcase
  end

  state_t           state;
  logic [OUT_W-1:0] head_imm, tail_imm;
  mode_t            head_mode, tail_mode;
  logic             push, pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head registers may hold stale data when empty; mask keeps idle outputs clean.
  assign out_imm  = out_valid ? head_imm : '0;
  assign out_mode = out_valid ? head_mode : M_NONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      head_imm  <= '0;
      tail_imm  <= '0;
      head_mode <= M_NONE;
      tail_mode <= M_NONE;
      ext_count <= '0;
    end else begin
      if (pop)
        ext_count <= ext_count + CNT_W'(1);
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: if (push) begin
            head_imm  <= dec_imm;
            head_mode <= dec_mode;
            state     <= HALF;
          end
          HALF: begin
            if (push && pop) begin
              head_imm  <= dec_imm;
              head_mode <= dec_mode;
            end else if (push) begin
              tail_imm  <= dec_imm;
              tail_mode <= dec_mode;
              state     <= FULL;
            end else if (pop) begin
              state <= EMPTY;
            end
          end
          FULL: if (pop) begin
            head_imm  <= tail_imm;
            head_mode <= tail_mode;
            state     <= HALF;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: a vector table streamed at full rate plus
// hand-written stall, flush and mid-stream reset sequences.
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_mode;
  logic [15:0] ext_count;

  int total = 0;
  int bad   = 0;

  imm_ext_stage #(.IMM_W(16), .OUT_W(32), .BR_SHIFT(2), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_mode  (out_mode),
    .ext_count (ext_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  mode;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_head(input string name, input vec_t v);
    chk({name, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, ".imm"}, out_imm, v.imm);
    chk({name, ".mode"}, {29'b0, out_mode}, {29'b0, v.mode});
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, ".imm"}, out_imm, 32'd0);
    chk({name, ".mode"}, {29'b0, out_mode}, 32'd7);
  endtask

  initial begin
    vecs[0]  = '{32'h2008FFFF, 32'hFFFFFFFF, 3'd0};  // addi
    vecs[1]  = '{32'h3108FFFF, 32'h0000FFFF, 3'd1};  // andi
    vecs[2]  = '{32'h3C081234, 32'h12340000, 3'd2};  // lui
    vecs[3]  = '{32'h1000FFFE, 32'hFFFFFFF8, 3'd3};  // beq -2
    vecs[4]  = '{32'h00084080, 32'h00000002, 3'd4};  // sll 2
    vecs[5]  = '{32'h08000010, 32'h00000010, 3'd5};  // j
    vecs[6]  = '{32'h0FFFFFFF, 32'h03FFFFFF, 3'd5};  // jal max target
    vecs[7]  = '{32'h8C087FFC, 32'h00007FFC, 3'd0};  // lw
    vecs[8]  = '{32'hAC088000, 32'hFFFF8000, 3'd0};  // sw negative
    vecs[9]  = '{32'h35081234, 32'h00001234, 3'd1};  // ori
    vecs[10] = '{32'h39088001, 32'h00008001, 3'd1};  // xori
    vecs[11] = '{32'h14007FFF, 32'h0001FFFC, 3'd3};  // bne max positive
    vecs[12] = '{32'h1C000001, 32'h00000004, 3'd3};  // bgtz
    vecs[13] = '{32'h04010005, 32'h00000000, 3'd7};  // regimm -> none
    vecs[14] = '{32'h40800000, 32'h00000000, 3'd7};  // cop0 -> none
    vecs[15] = '{32'h28080001, 32'h00000001, 3'd0};  // slti
    vecs[16] = '{32'h10008000, 32'hFFFE0000, 3'd3};  // beq most negative

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    #1;
    chk_idle("rst");
    chk("rst.cnt", {16'b0, ext_count}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

    // Full-rate stream through the table: one pop per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int unsigned i = 0; i < 17; i++) begin
      instr = vecs[i].instr;
      tick();
      chk_head($sformatf("vec%0d", i), vecs[i]);
      chk("stream.in_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_idle("stream.end");
    chk("stream.cnt", {16'b0, ext_count}, 32'd17);

    // Stall: third instruction is held off until the consumer drains.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = vecs[2].instr; tick();
    chk_head("stall.a", vecs[2]);
    chk("stall.rdy1", {31'b0, in_ready}, 32'd1);
    instr = vecs[3].instr; tick();
    chk_head("stall.a_held", vecs[2]);
    chk("stall.rdy_full", {31'b0, in_ready}, 32'd0);
    instr = vecs[4].instr; tick();
    chk_head("stall.a_still", vecs[2]);
    chk("stall.rdy_still", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    chk_head("stall.b", vecs[3]);
    chk("stall.rdy_half", {31'b0, in_ready}, 32'd1);
    tick();
    chk_head("stall.c", vecs[4]);
    in_valid = 1'b0; tick();
    chk_idle("stall.end");
    chk("stall.cnt", {16'b0, ext_count}, 32'd20);

    // Flush while FULL with a push offered and no pop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = vecs[0].instr; tick();
    instr = vecs[1].instr; tick();
    chk("flush.full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1; instr = vecs[2].instr; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_idle("flush");
    chk("flush.in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush.cnt", {16'b0, ext_count}, 32'd20);
    tick();
    chk_idle("flush.no_push");

    // Flush in the same cycle as a pop: the pop still counts.
    in_valid = 1'b1; instr = vecs[5].instr; tick();
    chk_head("flushpop.pre", vecs[5]);
    out_ready = 1'b1; flush = 1'b1; instr = vecs[6].instr; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_idle("flushpop");
    chk("flushpop.cnt", {16'b0, ext_count}, 32'd21);

    // Asynchronous reset mid-stream with two entries held.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = vecs[7].instr; tick();
    instr = vecs[8].instr; tick();
    chk("midrst.full", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_idle("midrst");
    chk("midrst.cnt", {16'b0, ext_count}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk_idle("midrst.after");

    // Eight back-to-back operands from a fresh count.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      instr = vecs[i].instr;
      tick();
      chk_head($sformatf("b2b%0d", i), vecs[i]);
    end
    in_valid = 1'b0;
    tick();
    chk_idle("b2b.end");
    chk("b2b.cnt", {16'b0, ext_count}, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
